// File: rtl/mult_pipe_if.sv
// Issue/RS-side and CDB-side signals of the pipelined multiplier.
// The issuing side uses the master modport and the multiplier uses the slave modport.
interface mult_pipe_if #(
    parameter int XLEN      = 64,
    parameter int ROB_IDX_W = 5,
    parameter int PRF_IDX_W = 6
);
    logic                 start_i;
    logic [XLEN-1:0]      opa_i;
    logic [XLEN-1:0]      opb_i;
    logic                 hi_i;
    logic [ROB_IDX_W-1:0] rob_idx_i;
    logic [PRF_IDX_W-1:0] dest_tag_i;
    logic                 flush_i;
    logic                 stall_i;

    logic                 ready_o;
    logic                 done_o;
    logic [XLEN-1:0]      product_o;
    logic [ROB_IDX_W-1:0] rob_idx_o;
    logic [PRF_IDX_W-1:0] dest_tag_o;
    logic                 busy_o;

    modport master (
        output start_i, opa_i, opb_i, hi_i, rob_idx_i, dest_tag_i, flush_i, stall_i,
        input  ready_o, done_o, product_o, rob_idx_o, dest_tag_o, busy_o
    );

    modport slave (
        input  start_i, opa_i, opb_i, hi_i, rob_idx_i, dest_tag_i, flush_i, stall_i,
        output ready_o, done_o, product_o, rob_idx_o, dest_tag_o, busy_o
    );
endinterface

// File: rtl/mult_pipe.sv
// Fully pipelined unsigned XLEN x XLEN multiplier; each stage folds one CHUNK-bit
// multiplier slice into a 2*XLEN accumulator and returns the low or high half.
module mult_pipe #(
    parameter int XLEN      = 64,
    parameter int NUM_STAGE = 4,
    parameter int ROB_IDX_W = 5,
    parameter int PRF_IDX_W = 6
) (
    input  logic     clock,
    input  logic     reset,
    mult_pipe_if.slave bus
);
    localparam int CHUNK = XLEN / NUM_STAGE;
    localparam int PW    = 2 * XLEN;

    logic                 ready;
    logic                 done;
    logic [NUM_STAGE-1:0] valid_q;
    logic [NUM_STAGE-1:0] hi_q;
    logic [ROB_IDX_W-1:0] rob_q [NUM_STAGE];
    logic [PRF_IDX_W-1:0] tag_q [NUM_STAGE];

    // Stage boundaries: element k is the input of stage k, acc_b[NUM_STAGE] the final product.
    logic [PW-1:0]   acc_b    [NUM_STAGE+1];
    logic [PW-1:0]   mcand_b  [NUM_STAGE];
    logic [XLEN-1:0] mplier_b [NUM_STAGE];
    logic [PW-1:0]   acc_fin;

    assign done  = valid_q[NUM_STAGE-1];
    assign ready = !(done && bus.stall_i);

    assign acc_b[0]    = '0;
    assign mcand_b[0]  = {{XLEN{1'b0}}, bus.opa_i};
    assign mplier_b[0] = bus.opb_i;

    always_ff @(posedge clock) begin
        if (reset || bus.flush_i) begin
            valid_q <= '0;
        end else if (ready) begin
            valid_q[0] <= bus.start_i;
            for (int k = 1; k < NUM_STAGE; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    // Tags ride alongside the datapath; stale contents are masked by valid_q.
    always_ff @(posedge clock) begin
        if (ready) begin
            hi_q[0]  <= bus.hi_i;
            rob_q[0] <= bus.rob_idx_i;
            tag_q[0] <= bus.dest_tag_i;
            for (int k = 1; k < NUM_STAGE; k++) begin
                hi_q[k]  <= hi_q[k-1];
                rob_q[k] <= rob_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        logic [PW-1:0] acc_q;

        always_ff @(posedge clock) begin
            if (ready) begin
                acc_q <= acc_b[k] + mcand_b[k] * PW'(mplier_b[k][CHUNK-1:0]);
            end
        end
        assign acc_b[k+1] = acc_q;

        // The last stage has no consumer for the shifted operands.
        if (k < NUM_STAGE - 1) begin : g_fwd
            logic [PW-1:0]   mcand_q;
            logic [XLEN-1:0] mplier_q;

            always_ff @(posedge clock) begin
                if (ready) begin
                    mcand_q  <= mcand_b[k] << CHUNK;
                    mplier_q <= mplier_b[k] >> CHUNK;
                end
            end
            assign mcand_b[k+1]  = mcand_q;
            assign mplier_b[k+1] = mplier_q;
        end
    end

    assign acc_fin = acc_b[NUM_STAGE];

    assign bus.ready_o    = ready;
    assign bus.done_o     = done;
    assign bus.busy_o     = |valid_q;
    assign bus.product_o  = !done                ? '0 :
                            hi_q[NUM_STAGE-1]    ? acc_fin[PW-1:XLEN] :
                                                   acc_fin[XLEN-1:0];
    assign bus.rob_idx_o  = done ? rob_q[NUM_STAGE-1] : '0;
    assign bus.dest_tag_o = done ? tag_q[NUM_STAGE-1] : '0;
endmodule
